dmem_arbiter: RTL and testbench

Shares the single-port data memory (synchronous-read, 1-cycle read latency, 4096 x 32) between the processor's MM-stage data port and a host port used for program/data loading and debug readback. The CPU has priority; a saturating wait counter bounds host latency by forcing a one-cycle CPU stall. Sits between the pipeline's MM stage and the `dmem` instance.

---
 rtl/dmem_arbiter.sv | 60 ++++++
 tb/tb_dmem_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU MM stage and a host port,
// CPU first, with a saturating wait counter that forces a one-cycle CPU stall for the host.
module dmem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_hold,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out
);
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_HOST} own_t;
  own_t       rd_own, rd_own_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic       cpu_act, wait_full;
  always_comb begin
    cpu_act    = cpu_re | cpu_we;
    wait_full  = wait_cnt == 8'(MAX_WAIT);
    host_gnt   = rst_n & host_req & (!cpu_act | host_hold | wait_full);
    cpu_stall  = rst_n & cpu_act & (host_gnt | host_hold);
    mem_addr   = host_gnt ? host_addr : cpu_addr;
    mem_in     = host_gnt ? host_wdata : cpu_wdata;
    mem_we     = host_gnt ? host_we : rst_n & cpu_we & !cpu_stall;
    wait_nxt   = (host_gnt | !host_req) ? 8'd0 : wait_full ? wait_cnt : wait_cnt + 8'd1;
    rd_own_nxt = (host_gnt & !host_we) ? OWN_HOST :
                 (cpu_re & !cpu_we & !cpu_stall) ? OWN_CPU : OWN_NONE;
  end
  // An async reset drops any read still in flight, so its rvalid never appears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 8'd0;
      rd_own   <= OWN_NONE;
    end else begin
      wait_cnt <= wait_nxt;
      rd_own   <= rd_own_nxt;
    end
  end
  assign cpu_rvalid  = rd_own == OWN_CPU;
  assign host_rvalid = rd_own == OWN_HOST;
  assign cpu_rdata   = mem_out;
  assign host_rdata  = mem_out;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors against dmem_arbiter with a behavioural 4096x32 sync-read memory.
module tb_dmem_arbiter;
  logic        clk = 0, rst_n = 0;
  logic        cpu_re = 0, cpu_we = 0, cpu_stall, cpu_rvalid;
  logic [11:0] cpu_addr = 0, host_addr = 0, mem_addr;
  logic [31:0] cpu_wdata = 0, cpu_rdata, host_wdata = 0, host_rdata, mem_in, mem_out;
  logic        host_hold = 0, host_req = 0, host_we = 0, host_gnt, host_rvalid, mem_we;
  logic [31:0] mem [4096];
  int          n_vec = 0, n_bad = 0;

  dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_WAIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_hold(host_hold), .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_in(mem_in), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_in;
    mem_out <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    // reset with every request asserted: nothing may leak out
    cpu_re = 1; cpu_we = 1; host_req = 1; host_we = 1;
    @(negedge clk); #1;
    check("rst_mem_we", mem_we, 0);
    check("rst_host_gnt", host_gnt, 0);
    check("rst_cpu_stall", cpu_stall, 0);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_host_rvalid", host_rvalid, 0);
    check("rst_wait_cnt", dut.wait_cnt, 0);
    cpu_re = 0; cpu_we = 0; host_req = 0; host_we = 0;
    @(negedge clk); rst_n = 1;

    // CPU-only write then read
    cpu_we = 1; cpu_addr = 12'h010; cpu_wdata = 32'h1234_5678; #1;
    check("cw_stall", cpu_stall, 0);
    check("cw_mem_we", mem_we, 1);
    check("cw_mem_addr", mem_addr, 12'h010);
    cyc();
    cpu_we = 0; cpu_re = 1; #1;
    check("cr_stall", cpu_stall, 0);
    check("cr_mem_we", mem_we, 0);
    cyc();
    cpu_re = 0;
    check("cr_rvalid", cpu_rvalid, 1);
    check("cr_rdata", cpu_rdata, 32'h1234_5678);
    check("cr_host_rvalid", host_rvalid, 0);
    cyc();
    check("cr_rvalid_drop", cpu_rvalid, 0);

    // idle CPU: host write then read at the top address
    host_req = 1; host_we = 1; host_addr = 12'hFFF; host_wdata = 32'hDEAD_BEEF; #1;
    check("hw_gnt", host_gnt, 1);
    check("hw_mem_we", mem_we, 1);
    check("hw_mem_addr", mem_addr, 12'hFFF);
    check("hw_mem_in", mem_in, 32'hDEAD_BEEF);
    cyc();
    check("hw_no_rvalid", host_rvalid, 0);
    host_we = 0; #1;
    check("hr_gnt", host_gnt, 1);
    check("hr_mem_we", mem_we, 0);
    cyc();
    host_req = 0;
    check("hr_rvalid", host_rvalid, 1);
    check("hr_rdata", host_rdata, 32'hDEAD_BEEF);
    check("hr_cpu_rvalid", cpu_rvalid, 0);
    cyc();

    // CPU reads every cycle, host read starves until wait_cnt hits 8
    cpu_addr = 12'h010;
    for (int c = 0; c <= 10; c++) begin
      cpu_re = c <= 9;
      host_req = c <= 8;
      #1;
      if (c <= 9) begin
        check($sformatf("st_gnt_c%0d", c), host_gnt, c == 8);
        check($sformatf("st_stall_c%0d", c), cpu_stall, c == 8);
      end
      if (c >= 1) begin
        check($sformatf("st_cpu_rvalid_c%0d", c), cpu_rvalid, c != 9);
        check($sformatf("st_host_rvalid_c%0d", c), host_rvalid, c == 9);
      end
      if (c == 9) check("st_host_rdata", host_rdata, 32'hDEAD_BEEF);
      if (c == 10) check("st_cpu_rdata", cpu_rdata, 32'h1234_5678);
      cyc();
    end
    cpu_re = 0;
    cyc();

    // host_req dropped before grant clears the counter and issues nothing
    cpu_re = 1; host_req = 1; host_addr = 12'hFFF;
    cyc(); cyc(); cyc();
    check("drop_wait_cnt", dut.wait_cnt, 3);
    check("drop_gnt", host_gnt, 0);
    host_req = 0;
    cyc();
    check("drop_wait_clr", dut.wait_cnt, 0);
    cyc();
    check("drop_host_rvalid", host_rvalid, 0);
    cpu_re = 0;
    cyc();

    // CPU read, then host_hold rises: held writes stall, earlier read still returns
    cpu_re = 1; cpu_addr = 12'h010;
    cyc();
    cpu_re = 0; cpu_we = 1; cpu_wdata = 32'hFFFF_FFFF; host_hold = 1; #1;
    check("hold_rvalid", cpu_rvalid, 1);
    check("hold_rdata", cpu_rdata, 32'h1234_5678);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("hold_stall_%0d", c), cpu_stall, 1);
      check($sformatf("hold_mem_we_%0d", c), mem_we, 0);
      cyc();
    end
    cpu_we = 0; host_hold = 0; cpu_re = 1;
    cyc();
    cpu_re = 0;
    check("hold_unchanged", cpu_rdata, 32'h1234_5678);
    cyc();

    // host read granted, then reset straddles the capture edge
    host_req = 1; host_we = 0; host_addr = 12'hFFF; #1;
    check("rr_gnt", host_gnt, 1);
    #1 rst_n = 0; cpu_we = 1; #1;
    check("rr_mem_we", mem_we, 0);
    check("rr_gnt_rst", host_gnt, 0);
    host_req = 0; cpu_we = 0;
    @(posedge clk); #2 rst_n = 1;
    @(negedge clk);
    check("rr_host_rvalid", host_rvalid, 0);
    check("rr_wait_cnt", dut.wait_cnt, 0);
    cyc();

    // simultaneous re/we is a write
    cpu_re = 1; cpu_we = 1; cpu_addr = 12'h020; cpu_wdata = 32'h5; #1;
    check("rw_mem_we", mem_we, 1);
    check("rw_stall", cpu_stall, 0);
    cyc();
    cpu_we = 0;
    check("rw_no_rvalid", cpu_rvalid, 0);
    cyc();
    cpu_re = 0;
    check("rw_rvalid", cpu_rvalid, 1);
    check("rw_rdata", cpu_rdata, 32'h5);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
